// File: rtl/md5_block_engine_pkg.sv
// Shared MD5 definitions: IV, FSM states, S/T tables, message index and digest ordering.
// MD5_DIGEST_LE_EN selects standard byte-ordered digest output instead of raw h0..h3 words.
package md5_block_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FINAL = 2'd3
  } md5_state_e;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hefcdab89;
  localparam logic [31:0] IV_H2 = 32'h98badcfe;
  localparam logic [31:0] IV_H3 = 32'h10325476;

  localparam logic [31:0] T_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every four steps within a round: indexed by {round, step mod 4}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] md5_bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] md5_t(input logic [5:0] i);
    return T_TAB[i];
  endfunction

  function automatic logic [4:0] md5_s(input logic [1:0] rnd, input logic [1:0] col);
    return S_TAB[{rnd, col}];
  endfunction

  // Only i mod 16 matters since 5, 3 and 7 times 16 vanish modulo 16.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] g;
    case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = i[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i[3:0] * 4'd3 + 4'd5;
      default: g = i[3:0] * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [127:0] md5_digest(input logic [31:0] h0, input logic [31:0] h1,
                                              input logic [31:0] h2, input logic [31:0] h3);
`ifdef MD5_DIGEST_LE_EN
    return {md5_bswap(h0), md5_bswap(h1), md5_bswap(h2), md5_bswap(h3)};
`else
    return {h0, h1, h2, h3};
`endif
  endfunction

endpackage

// File: rtl/md5_block_engine_step.sv
// Combinational single MD5 step: returns the new b word from a,b,c,d, message word, shift and constant.
module md5_block_engine_step
  import md5_block_engine_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] t,
  input  logic [4:0]  s,
  input  logic [1:0]  round,
  output logic [31:0] b_new
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;

  always_comb begin
    f = 32'h0;
    case (round)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
  end

  assign sum   = a + f + m + t;
  assign rot   = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
  assign b_new = b + rot;

endmodule

// File: rtl/md5_block_engine.sv
// MD5 block engine: buffers 16 words, runs 64 steps at STEPS_PER_CYCLE per clock, chains h0..h3.
// Output byte order controlled by MD5_DIGEST_LE_EN (see package).
module md5_block_engine
  import md5_block_engine_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit OUT_REG         = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         init_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [31:0]  msg_i,
  output logic         busy_o,
  output logic         hash_valid_o,
  output logic [127:0] hash_o
);

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_steps
    $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [5:0] STEP_INC  = 6'(STEPS_PER_CYCLE);
  localparam logic [5:0] LAST_STEP = 6'(64 - STEPS_PER_CYCLE);

  // Async assert, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  md5_state_e  state_q, state_d;
  logic [3:0]  count_q;
  logic [5:0]  step_q;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] h0_q, h1_q, h2_q, h3_q;
  logic [31:0] msg_buf [16];
  logic        hash_valid_q;
  logic        xfer;
  logic [31:0] a_nx, b_nx, c_nx, d_nx;
  logic [31:0] sum0, sum1, sum2, sum3;

  always_comb begin
    state_d     = state_q;
    msg_ready_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i && count_q == 4'd15) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (step_q == LAST_STEP) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        busy_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer = msg_valid_i & msg_ready_o;

  // Message buffer is always fully rewritten before a block runs, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (xfer) msg_buf[count_q] <= md5_bswap(msg_i);
  end

  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
    logic [5:0]  idx;
    logic [31:0] a_in, b_in, c_in, d_in, b_new;

    assign idx = step_q + 6'(k);

    if (k == 0) begin : g_head
      assign a_in = a_q;
      assign b_in = b_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_link
      assign a_in = g_step[k-1].d_in;
      assign b_in = g_step[k-1].b_new;
      assign c_in = g_step[k-1].b_in;
      assign d_in = g_step[k-1].c_in;
    end

    md5_block_engine_step u_step (
      .a     (a_in),
      .b     (b_in),
      .c     (c_in),
      .d     (d_in),
      .m     (msg_buf[md5_g(idx)]),
      .t     (md5_t(idx)),
      .s     (md5_s(idx[5:4], idx[1:0])),
      .round (idx[5:4]),
      .b_new (b_new)
    );
  end

  assign a_nx = g_step[STEPS_PER_CYCLE-1].d_in;
  assign b_nx = g_step[STEPS_PER_CYCLE-1].b_new;
  assign c_nx = g_step[STEPS_PER_CYCLE-1].b_in;
  assign d_nx = g_step[STEPS_PER_CYCLE-1].c_in;

  assign sum0 = h0_q + a_q;
  assign sum1 = h1_q + b_q;
  assign sum2 = h2_q + c_q;
  assign sum3 = h3_q + d_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= 4'd0;
      step_q       <= 6'd0;
      {a_q, b_q, c_q, d_q} <= 128'h0;
      h0_q         <= IV_H0;
      h1_q         <= IV_H1;
      h2_q         <= IV_H2;
      h3_q         <= IV_H3;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hash_valid_q <= (state_q == ST_FINAL);
      if (xfer) count_q <= count_q + 4'd1;
      if (state_q == ST_IDLE && init_i) begin
        h0_q <= IV_H0;
        h1_q <= IV_H1;
        h2_q <= IV_H2;
        h3_q <= IV_H3;
      end
      if (state_q == ST_LOAD && xfer && count_q == 4'd15) begin
        {a_q, b_q, c_q, d_q} <= {h0_q, h1_q, h2_q, h3_q};
        step_q <= 6'd0;
      end
      if (state_q == ST_RUN) begin
        {a_q, b_q, c_q, d_q} <= {a_nx, b_nx, c_nx, d_nx};
        step_q <= step_q + STEP_INC;
      end
      if (state_q == ST_FINAL) begin
        {h0_q, h1_q, h2_q, h3_q} <= {sum0, sum1, sum2, sum3};
        count_q <= 4'd0;
      end
    end
  end

  assign hash_valid_o = hash_valid_q;

  if (OUT_REG) begin : g_out_reg
    logic [127:0] hash_q;
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)                     hash_q <= md5_digest(IV_H0, IV_H1, IV_H2, IV_H3);
      else if (state_q == ST_FINAL)   hash_q <= md5_digest(sum0, sum1, sum2, sum3);
    end
    assign hash_o = hash_q;
  end else begin : g_out_comb
    assign hash_o = md5_digest(h0_q, h1_q, h2_q, h3_q);
  end

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed bench for md5_block_engine; expected digests follow MD5_DIGEST_LE_EN when defined.
module tb_md5_block_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init;
  logic         msg_valid;
  logic [31:0]  msg;
  logic [2:0]   en;
  logic         v1, v2, v4;
  logic         rdy1, rdy2, rdy4;
  logic         busy1, busy2, busy4;
  logic         hv1, hv2, hv4;
  logic [127:0] hash1, hash2, hash4;

  int checks = 0;
  int errors = 0;
  int hv_cnt1 = 0;
  int xfer_cnt1 = 0;

  always #5 clk = ~clk;

  assign v1 = msg_valid & en[0];
  assign v2 = msg_valid & en[1];
  assign v4 = msg_valid & en[2];

  md5_block_engine #(.STEPS_PER_CYCLE(1), .OUT_REG(1'b1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .msg_valid_i(v1), .msg_ready_o(rdy1),
    .msg_i(msg), .busy_o(busy1), .hash_valid_o(hv1), .hash_o(hash1));
  md5_block_engine #(.STEPS_PER_CYCLE(2), .OUT_REG(1'b0)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .msg_valid_i(v2), .msg_ready_o(rdy2),
    .msg_i(msg), .busy_o(busy2), .hash_valid_o(hv2), .hash_o(hash2));
  md5_block_engine #(.STEPS_PER_CYCLE(4), .OUT_REG(1'b1)) u_s4 (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .msg_valid_i(v4), .msg_ready_o(rdy4),
    .msg_i(msg), .busy_o(busy4), .hash_valid_o(hv4), .hash_o(hash4));

`ifdef MD5_DIGEST_LE_EN
  localparam logic [127:0] ABC_EXP   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] EMPTY_EXP = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] IV_OUT    = 128'h0123456789abcdeffedcba9876543210;
`else
  localparam logic [127:0] ABC_EXP   = 128'h98500190b04fd23c7d3f96d6727fe128;
  localparam logic [127:0] EMPTY_EXP = 128'hd98c1dd404b2008f980980e97e42f8ec;
  localparam logic [127:0] IV_OUT    = 128'h67452301efcdab8998badcfe10325476;
`endif
  localparam logic [127:0] IV_RAW = 128'h67452301efcdab8998badcfe10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a,
    32'ha8304613, 32'hfd469501, 32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821, 32'hf61e2562, 32'hc040b340,
    32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8,
    32'h676f02d9, 32'h8d2a4c8a, 32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70, 32'h289b7ec6, 32'heaa127fa,
    32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92,
    32'hffeff47d, 32'h85845dd1, 32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
  localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  function automatic logic [31:0] bs(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reference compression of one block from stream-order words; h packed as {h0,h1,h2,h3}.
  function automatic logic [127:0] md5_model(input logic [127:0] hin, input logic [31:0] w [16]);
    logic [31:0] a, b, c, d, f, tmp;
    int g;
    a = hin[127:96]; b = hin[95:64]; c = hin[63:32]; d = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      tmp = a + f + K[i] + bs(w[g]);
      tmp = (tmp << SH[i / 16][i % 4]) | (tmp >> (32 - SH[i / 16][i % 4]));
      a = d; d = c; c = b; b = b + tmp;
    end
    return {hin[127:96] + a, hin[95:64] + b, hin[63:32] + c, hin[31:0] + d};
  endfunction

  function automatic logic [127:0] exp_out(input logic [127:0] h);
`ifdef MD5_DIGEST_LE_EN
    return {bs(h[127:96]), bs(h[95:64]), bs(h[63:32]), bs(h[31:0])};
`else
    return h;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (hv1 === 1'b1) hv_cnt1++;
    if (msg_valid && en[0] && rdy1 === 1'b1) xfer_cnt1++;
  end

  // Called at a negedge; returns at the negedge after the word is taken.
  task automatic send_word(input logic [31:0] w, input logic ini);
    bit done = 1'b0;
    msg = w; init = ini; msg_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      done = rdy1;
      @(posedge clk); @(negedge clk);
    end
    msg_valid = 1'b0; init = 1'b0;
    if (!done) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic send_block(input logic [31:0] w [16], input logic ini, input int max_gap);
    for (int j = 0; j < 16; j++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_word(w[j], ini && (j == 0));
    end
  endtask

  task automatic wait_hv(output int lat, output logic [127:0] h);
    bit found = 1'b0;
    lat = 0; h = '0;
    for (int n = 1; n <= 300 && !found; n++) begin
      @(posedge clk); @(negedge clk);
      if (hv1 === 1'b1) begin found = 1'b1; lat = n; h = hash1; end
    end
    if (!found) chk("hash_valid_timeout", 128'd0, 128'd1);
  endtask

  logic [31:0]  blk_abc [16];
  logic [31:0]  blk_empty [16];
  logic [31:0]  blk_a64 [16];
  logic [31:0]  blk_pad [16];
  logic [31:0]  blk_rnd [16];
  logic [127:0] h_got, h_mid;
  int           lat, hv_base, xf_base;
  int           lats [3];
  logic [127:0] hs [3];

  initial begin
    for (int j = 0; j < 16; j++) begin
      blk_abc[j] = 32'h0; blk_empty[j] = 32'h0; blk_a64[j] = 32'h61616161;
      blk_pad[j] = 32'h0; blk_rnd[j] = $urandom();
    end
    blk_abc[0] = 32'h61626380; blk_abc[14] = 32'h18000000;
    blk_empty[0] = 32'h80000000;
    blk_pad[0] = 32'h80000000; blk_pad[14] = 32'h00020000;

    rst_n = 1'b1; init = 1'b0; msg_valid = 1'b0; msg = 32'h0; en = 3'b000;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hash_s1", hash1, IV_OUT);
    chk("rst_hash_s2", hash2, IV_OUT);
    chk("rst_hash_s4", hash4, IV_OUT);
    chk("rst_ready", 128'({rdy1, rdy2, rdy4}), 128'd7);
    chk("rst_busy", 128'({busy1, busy2, busy4}), 128'd0);
    chk("rst_hv", 128'({hv1, hv2, hv4}), 128'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Empty message on all three step widths in parallel.
    en = 3'b111;
    send_block(blk_empty, 1'b1, 0);
    lats = '{0, 0, 0};
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); @(negedge clk);
      if (hv1 === 1'b1 && lats[0] == 0) begin lats[0] = n; hs[0] = hash1; end
      if (hv2 === 1'b1 && lats[1] == 0) begin lats[1] = n; hs[1] = hash2; end
      if (hv4 === 1'b1 && lats[2] == 0) begin lats[2] = n; hs[2] = hash4; end
    end
    chk("empty_lat_s1", 128'(lats[0]), 128'd65);
    chk("empty_lat_s2", 128'(lats[1]), 128'd33);
    chk("empty_lat_s4", 128'(lats[2]), 128'd17);
    chk("empty_hash_s1", hs[0], EMPTY_EXP);
    chk("empty_hash_s2", hs[1], EMPTY_EXP);
    chk("empty_hash_s4", hs[2], EMPTY_EXP);
    en = 3'b001;

    // "abc" with init, plus one-cycle pulse width.
    send_block(blk_abc, 1'b1, 0);
    wait_hv(lat, h_got);
    chk("abc_hash", h_got, ABC_EXP);
    chk("abc_lat", 128'(lat), 128'd65);
    @(posedge clk); @(negedge clk);
    chk("abc_hv_width", 128'(hv1), 128'd0);

    // Two-block chain, init only on the first block.
    hv_base = hv_cnt1;
    send_block(blk_a64, 1'b1, 0);
    wait_hv(lat, h_mid);
    chk("chain_blk1", h_mid, exp_out(md5_model(IV_RAW, blk_a64)));
    send_block(blk_pad, 1'b0, 0);
    wait_hv(lat, h_got);
    chk("chain_blk2", h_got, exp_out(md5_model(md5_model(IV_RAW, blk_a64), blk_pad)));
    @(posedge clk); @(negedge clk);
    chk("chain_pulses", 128'(hv_cnt1 - hv_base), 128'd2);

    // Random gaps while loading, valid held high throughout RUN.
    xf_base = xfer_cnt1;
    send_block(blk_rnd, 1'b1, 3);
    msg = 32'hdeadbeef; msg_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk("busy_no_ready", 128'({busy1, rdy1}), 128'd2);
      @(posedge clk); @(negedge clk);
    end
    msg_valid = 1'b0;
    wait_hv(lat, h_got);
    chk("gap_hash", h_got, exp_out(md5_model(IV_RAW, blk_rnd)));
    @(posedge clk); @(negedge clk);
    chk("gap_xfers", 128'(xfer_cnt1 - xf_base), 128'd16);

    // Reset asserted around step 30 of a running block.
    send_block(blk_rnd, 1'b1, 0);
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", 128'(busy1), 128'd1);
    hv_base = hv_cnt1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hash", hash1, IV_OUT);
    chk("midrst_flags", 128'({rdy1, busy1, hv1}), 128'd4);
    repeat (3) @(negedge clk);
    chk("midrst_hold_hash", hash1, IV_OUT);
    chk("midrst_hold_flags", 128'({rdy1, busy1, hv1}), 128'd4);
    chk("midrst_no_pulse", 128'(hv_cnt1 - hv_base), 128'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_block(blk_abc, 1'b1, 0);
    wait_hv(lat, h_got);
    chk("post_rst_abc", h_got, ABC_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_block_engine.md
Name: md5_block_engine

Overview:
- Parametrised successor to the single-step MD5 round FSM.
- Accepts a 512-bit message block as 16 words over a valid/ready handshake and buffers it internally, so the caller no longer supplies words in round-permuted order.
- Runs the 64 MD5 steps at STEPS_PER_CYCLE steps per clock and chains blocks through the h0..h3 state.
- Sits between the host word-stream interface and the digest consumer.

Parameters:
- STEPS_PER_CYCLE, 1, MD5 steps evaluated per clock; legal values are 1, 2 and 4; any other value is a elaboration error.
- OUT_REG, 1, when 1 hash_o is driven from a dedicated register updated on FINAL; when 0 it is driven directly from h0..h3.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- init_i  in  1  reload IV into h0..h3 before the next block; sampled only in IDLE.
- msg_valid_i  in  1  msg_i holds a valid word.
- msg_ready_o  out  1  block accepts a word this cycle.
- msg_i  in  32  four message bytes; first stream byte in msg_i[31:24].
- busy_o  out  1  block is in RUN or FINAL.
- hash_valid_o  out  1  one-cycle pulse: hash_o updated after a block.
- hash_o  out  128  digest h0..h3.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state = IDLE, word count = 0, step = 0.
  - h0..h3 = 67452301/efcdab89/98badcfe/10325476.
  - msg_ready_o = 1, busy_o = 0, hash_valid_o = 0.
  - hash_o = the digest of the IV under the selected output ordering.
- States:
  - IDLE: msg_ready_o = 1. On init_i, h0..h3 take the IV. A transfer (valid & ready) stores byte-swapped msg_i into buf[0], sets count = 1 and moves to LOAD. If init_i and a transfer occur in the same cycle, both take effect.
  - LOAD: msg_ready_o = 1. Each transfer writes buf[count] and increments count. The transfer that writes buf[15] moves to RUN; a..d load from h0..h3 and step = 0. Gaps in msg_valid_i stall without loss.
  - RUN: msg_ready_o = 0, busy_o = 1. Each cycle applies STEPS_PER_CYCLE chained steps i = step .. step+STEPS_PER_CYCLE-1, then step += STEPS_PER_CYCLE. Per step i:
    - g = i for i < 16; (5i+1) mod 16 for i < 32; (3i+5) mod 16 for i < 48; 7i mod 16 otherwise.
    - Round function is F/G/H/I by i/16; shift s and constant T come from the shared tables.
    - Registers rotate (a,b,c,d) <- (d,new,b,c).
    - After the cycle that completes step 63, go to FINAL.
  - FINAL: hN <= hN + working register, all arithmetic modulo 2^32. hash_valid_o = 1 for exactly this cycle's output. Return to IDLE with count = 0.
- Latency: 16 accepted words, then 64/STEPS_PER_CYCLE RUN cycles, then 1 FINAL cycle. With STEPS_PER_CYCLE = 1 that is 16+64+1 = 81 cycles minimum.
- Chaining: without init_i, the next block continues from the current h0..h3.
- init_i outside IDLE is ignored.
- A transfer attempted in RUN or FINAL is not accepted, because ready = 0.
- Reset mid-operation: the current block is discarded and all state returns to reset values.
- buf is not cleared on reset; it is written before each use.

Optional Feature:
- Macro: MD5_DIGEST_LE_EN.
- Defined: hash_o is the standard MD5 byte order, i.e. each hN is byte-swapped and h0 is in hash_o[127:96].
- Undefined: hash_o = {h0,h1,h2,h3} as raw words, no byte swap.

Decomposition:
- Shared header md5_defs.vh holds:
  - IV constants;
  - state encodings IDLE/LOAD/RUN/FINAL;
  - the 64-entry S and T tables, as the existing slut/tlut lookup or as functions;
  - the message-index function g(i).
- One natural sub-module: md5_step, a combinational single step (a,b,c,d,m,s,t,round -> new). It is instantiated STEPS_PER_CYCLE times in a chain, with the existing md5_core usable inside.

Test Plan:
- "abc" single block (default build, MD5_DIGEST_LE_EN defined, init_i=1 with the first word):
  - stimulus: msg_i = 61626380, then 13 × 00000000, then 18000000, 00000000;
  - required: hash_o = 900150983cd24fb0d6963f7d28e17f72, one hash_valid_o pulse.
- Empty message, run once for each STEPS_PER_CYCLE in 1, 2, 4:
  - stimulus: 80000000 followed by 15 zero words;
  - required: hash_o = d41d8cd98f00b204e9800998ecf8427e;
  - required: hash_valid_o exactly 64/S+1 cycles after the 16th transfer.
- Two-block chain, 64 bytes of 'a' plus a padding block, init_i only on block 1:
  - required: digest matches the software model;
  - required: hash_valid_o pulses twice.
- Random msg_valid_i gaps during LOAD and msg_valid_i held high during RUN:
  - required: no word accepted while busy_o = 1;
  - required: the digest equals the gap-free result.
- rst_ni asserted mid-RUN at step 30, then the "abc" block sent with init_i:
  - required: outputs hold reset values while rst_ni is low;
  - required: the next digest = 900150983cd24fb0d6963f7d28e17f72.
- Build with MD5_DIGEST_LE_EN undefined, "abc" block:
  - required: hash_o = 98500190b04fd23c7d3f96d6727fe128.
